// File: rtl/cook_pkg.sv
// Shared state encoding and default timing constants for the cook controller.
package cook_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREHEAT,
    COOK,
    PAUSE,
    FINISH
  } cook_state_e;

  localparam int LAMP_CYC_DEF = 3;
  localparam int TICK_DIV_DEF = 1000;

  // Counter width that stays at least one bit even for a count of one.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cook_hist_fifo.sv
// Show-ahead history FIFO of completed cook totals; a push into a full FIFO
// overwrites the oldest entry.
module cook_hist_fifo #(
  parameter int TIME_W     = 12,
  parameter int HIST_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [TIME_W-1:0] push_data,
  input  logic              pop,
  output logic [TIME_W-1:0] dout,
  output logic              valid,
  output logic              full
);

  localparam int PTR_W = $clog2(HIST_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(HIST_DEPTH);

  logic [TIME_W-1:0] mem_q [HIST_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pop_ok;
  logic              drop_oldest;

  // Pop is applied before push, so a full FIFO with both active loses only its head.
  always_comb begin
    valid       = (count_q != '0);
    full        = (count_q == DEPTH_C);
    pop_ok      = pop & valid;
    drop_oldest = push & full & ~pop_ok;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    if (pop_ok || drop_oldest) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (push && !pop_ok && !full) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign dout = valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/cook_controller.sv
// Microwave cook controller: preheat, timed cooking with door pause, and a
// finish phase that logs each completed cook's total time into a history FIFO.
module cook_controller
  import cook_pkg::*;
#(
  parameter int TIME_W     = 12,
  parameter int ADD_SEC    = 60,
  parameter int MAX_SEC    = 3599,
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int NUM_LVL    = 4,
  parameter int HIST_DEPTH = 8,
  parameter int LAMP_CYC   = LAMP_CYC_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       add_time,
  input  logic                       cancel,
  input  logic                       door_open,
  input  logic [$clog2(NUM_LVL)-1:0] level,
  input  logic                       hist_rd,
  output logic [NUM_LVL-1:0]         heat,
  output logic                       lamp,
  output logic [TIME_W-1:0]          remaining,
  output logic                       busy,
  output logic                       done,
  output logic                       hist_valid,
  output logic                       hist_full,
  output logic [TIME_W-1:0]          hist_dout
);

  localparam int LVL_W  = $clog2(NUM_LVL);
  localparam int TICK_W = clog2_min1(TICK_DIV);
  localparam int LAMP_W = clog2_min1(LAMP_CYC);
  localparam int EXT_W  = TIME_W + 2;

  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [LAMP_W-1:0]  LAMP_LAST = LAMP_W'(LAMP_CYC - 1);
  localparam logic [EXT_W-1:0]   ADD_EXT   = EXT_W'(ADD_SEC);
  localparam logic [EXT_W-1:0]   MAX_EXT   = EXT_W'(MAX_SEC);
  localparam logic [LVL_W-1:0]   LVL_MAX   = LVL_W'(NUM_LVL - 1);
  localparam logic [NUM_LVL-1:0] HEAT_LSB  = NUM_LVL'(1);

  cook_state_e       state_q, state_d;
  logic [LAMP_W-1:0] lamp_cnt_q, lamp_cnt_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [TIME_W-1:0] remaining_q, remaining_d;
  logic [TIME_W-1:0] total_q, total_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              done_q, done_d;
  logic              tick;
  logic              push_hist;

  // Optional one-second decrement plus optional button add, clamped to MAX_SEC.
  function automatic logic [TIME_W-1:0] sat_step(input logic [TIME_W-1:0] base,
                                                 input logic dec,
                                                 input logic inc);
    logic [EXT_W-1:0] sum;
    sum = EXT_W'(base);
    if (dec && (base != '0)) begin
      sum = sum - EXT_W'(1);
    end
    if (inc) begin
      sum = sum + ADD_EXT;
    end
    if (sum > MAX_EXT) begin
      sum = MAX_EXT;
    end
    return sum[TIME_W-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    lamp_cnt_d  = lamp_cnt_q;
    tick_cnt_d  = tick_cnt_q;
    remaining_d = remaining_q;
    total_d     = total_q;
    level_d     = level_q;
    done_d      = 1'b0;
    push_hist   = 1'b0;
    tick        = (state_q == COOK) && (tick_cnt_q == TICK_LAST);

    unique case (state_q)
      IDLE: begin
        if ((start || add_time) && !door_open) begin
          state_d     = PREHEAT;
          remaining_d = sat_step('0, 1'b0, 1'b1);
          total_d     = sat_step('0, 1'b0, 1'b1);
          lamp_cnt_d  = '0;
          tick_cnt_d  = '0;
          if (int'(level) > NUM_LVL - 1) begin
            level_d = LVL_MAX;
          end else begin
            level_d = level;
          end
        end
      end

      PREHEAT: begin
        remaining_d = sat_step(remaining_q, 1'b0, add_time);
        total_d     = sat_step(total_q, 1'b0, add_time);
        if (lamp_cnt_q == LAMP_LAST) begin
          state_d    = COOK;
          tick_cnt_d = '0;
        end else begin
          lamp_cnt_d = lamp_cnt_q + LAMP_W'(1);
        end
      end

      // An open door freezes the timer outright, ignoring any add that cycle.
      COOK: begin
        if (door_open) begin
          state_d = PAUSE;
        end else begin
          tick_cnt_d  = tick ? '0 : tick_cnt_q + TICK_W'(1);
          remaining_d = sat_step(remaining_q, tick, add_time);
          total_d     = sat_step(total_q, 1'b0, add_time);
          if (remaining_d == '0) begin
            state_d    = FINISH;
            lamp_cnt_d = '0;
            done_d     = 1'b1;
            push_hist  = 1'b1;
          end
        end
      end

      PAUSE: begin
        remaining_d = sat_step(remaining_q, 1'b0, add_time);
        total_d     = sat_step(total_q, 1'b0, add_time);
        if (start && !door_open) begin
          state_d = COOK;
        end
      end

      FINISH: begin
        if (lamp_cnt_q == LAMP_LAST) begin
          state_d = IDLE;
        end else begin
          lamp_cnt_d = lamp_cnt_q + LAMP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Cancel overrides everything, including a finish decided this cycle.
    if (cancel && (state_q != IDLE)) begin
      state_d     = IDLE;
      remaining_d = '0;
      tick_cnt_d  = '0;
      lamp_cnt_d  = '0;
      done_d      = 1'b0;
      push_hist   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lamp_cnt_q  <= '0;
      tick_cnt_q  <= '0;
      remaining_q <= '0;
      total_q     <= '0;
      level_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lamp_cnt_q  <= lamp_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      remaining_q <= remaining_d;
      total_q     <= total_d;
      level_q     <= level_d;
      done_q      <= done_d;
    end
  end

  // Heater drops in the same cycle the door opens or cancel is pressed.
  always_comb begin
    heat = '0;
    if ((state_q == COOK) && !door_open && !cancel) begin
      heat = HEAT_LSB << level_q;
    end
  end

  assign lamp      = (state_q != IDLE);
  assign busy      = (state_q != IDLE);
  assign remaining = remaining_q;
  assign done      = done_q;

  cook_hist_fifo #(
    .TIME_W     (TIME_W),
    .HIST_DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk       (clk),
    .reset     (reset),
    .push      (push_hist),
    .push_data (total_d),
    .pop       (hist_rd),
    .dout      (hist_dout),
    .valid     (hist_valid),
    .full      (hist_full)
  );

endmodule

// File: doc/cook_controller.md
COOK_CONTROLLER -- requirements
Module: cook_controller

Interface
REQ-001 Parameter TIME_W, 12, width of all seconds counters and history words.
REQ-002 Parameter ADD_SEC, 60, seconds added per add_time press.
REQ-003 Parameter MAX_SEC, 3599, saturation ceiling for remaining and total time.
REQ-004 Parameter TICK_DIV, 1000, clk cycles per one-second tick.
REQ-005 Parameter NUM_LVL, 4, number of power levels; heat is one-hot of this width.
REQ-006 Parameter HIST_DEPTH, 8, history FIFO depth, power of two, >=2.
REQ-007 Parameter LAMP_CYC, 3, lamp-on cycles in PREHEAT and FINISH.
REQ-008 clk  in  1  single clock; all logic is on its rising edge.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 start  in  1  start or resume cooking.
REQ-011 add_time  in  1  add ADD_SEC seconds, one add per cycle asserted.
REQ-012 cancel  in  1  abort cooking.
REQ-013 door_open  in  1  door sensor, 1 = open.
REQ-014 level  in  $clog2(NUM_LVL)  power level, sampled on leaving IDLE.
REQ-015 hist_rd  in  1  pop history head.
REQ-016 heat  out  NUM_LVL  one-hot heater drive.
REQ-017 lamp  out  1  cavity lamp.
REQ-018 remaining  out  TIME_W  seconds left.
REQ-019 busy  out  1  state != IDLE.
REQ-020 done  out  1  one-cycle pulse on FINISH entry.
REQ-021 hist_valid / hist_full  out  1 each  FIFO not-empty / full.
REQ-022 hist_dout  out  TIME_W  show-ahead FIFO head (0 when empty).

Function
REQ-023 States SHALL be IDLE, PREHEAT, COOK, PAUSE, FINISH.
REQ-024 IDLE: (start|add_time) & ~door_open -> PREHEAT; remaining = total = ADD_SEC; level latched, clamped to NUM_LVL-1.
REQ-025 IDLE SHALL ignore start/add_time while door_open=1.
REQ-026 PREHEAT: lamp=1, heat=0 for LAMP_CYC cycles, then COOK; tick counter cleared on COOK entry.
REQ-027 COOK: heat = one-hot(latched level); lamp=1; tick counter counts 0..TICK_DIV-1, and its wrap cycle is a tick.
REQ-028 Per cycle in PREHEAT/COOK: remaining_next = min(remaining - tick + (add_time ? ADD_SEC : 0), MAX_SEC); total likewise adds ADD_SEC, saturating at MAX_SEC.
REQ-029 COOK: remaining_next == 0 -> FINISH; an add_time on the final tick keeps COOK.
REQ-030 COOK: door_open -> PAUSE; tick counter and remaining hold; heat=0 same cycle.
REQ-031 PAUSE: lamp=1, heat=0; add_time accepted; start & ~door_open -> COOK with tick counter resumed, not cleared.
REQ-032 cancel in any non-IDLE state SHALL go to IDLE, heat=0, remaining=0, no history write, no done.
REQ-033 Priority: cancel > door_open > tick/add_time.
REQ-034 FINISH entry: done=1 for one cycle, total pushed to FIFO; lamp=1 for LAMP_CYC cycles, then IDLE.
REQ-035 Push with FIFO full SHALL drop the oldest entry; count unchanged.
REQ-036 hist_rd & hist_valid pops the head; hist_rd when empty ignored.
REQ-037 Simultaneous push and pop: pop then push; when full, exactly one entry leaves.

Reset
REQ-038 reset SHALL immediately force state IDLE, heat=0, lamp=0, remaining=0, busy=0, done=0, FIFO empty, counters 0.
REQ-039 Reset mid-cook SHALL discard the cycle without history write.

Structure
REQ-040 Package cook_pkg SHALL hold the state enum and the LAMP_CYC/TICK_DIV defaults.
REQ-041 History FIFO SHALL be sub-module cook_hist_fifo (params TIME_W, HIST_DEPTH, overwrite-oldest).

Verification (ADD_SEC=5, TICK_DIV=4, LAMP_CYC=3, HIST_DEPTH=2, MAX_SEC=12)
REQ-042 start, level=2 -> 3 PREHEAT cycles, heat=4'b0100 for 20 cycles, done pulse, FIFO head=5.
REQ-043 add_time held 3 cycles in PREHEAT -> remaining saturates at 12, history entry 12.
REQ-044 door_open mid-COOK at remaining=3 -> heat=0, remaining held 3; close + start -> resumes, done after 12 more cycles.
REQ-045 cancel during COOK -> IDLE next cycle, hist_valid unchanged, no done.
REQ-046 three completed cycles (5,10,5) without reads -> hist_full=1, reads return 10 then 5.
REQ-047 reset asserted mid-COOK -> heat=0 immediately, remaining=0, FIFO empty.
